// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_stage
// Purpose  : Instruction-decode stage of the 5-stage MIPS-subset pipeline.
//            Drives the register-file read ports combinationally from the
//            fetched instruction, then registers the decoded ALU operation,
//            operands and write-back control for EX (the ID/EX register).
// Ports    : clk, rst          - clock, synchronous active-high reset
//            pc_i              - PC of the instruction (reserved, unused)
//            inst_i            - instruction from IF/ID
//            rdata1_i/rdata2_i - register-file read data (same cycle)
//            re1_o/re2_o       - read enables (combinational)
//            raddr1_o/raddr2_o - read addresses rs/rt (combinational)
//            aluop_o/alusel_o  - ALU sub-operation / result class (registered)
//            rdata1_o/rdata2_o - operands (registered)
//            waddr_reg_o/we_reg_o - destination register / enable (registered)
// Revision : 1.0 - initial release
// ============================================================================
module id_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] rdata1_i,
  input  logic [31:0] rdata2_i,
  output logic        re1_o,
  output logic        re2_o,
  output logic [4:0]  raddr1_o,
  output logic [4:0]  raddr2_o,
  output logic [7:0]  aluop_o,
  output logic [2:0]  alusel_o,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o,
  output logic [4:0]  waddr_reg_o,
  output logic        we_reg_o
);

  localparam logic [2:0] SEL_NOP   = 3'b000;
  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;
  localparam logic [2:0] SEL_ARITH = 3'b100;

  localparam logic [7:0] OP_NOP  = 8'b0000_0000;
  localparam logic [7:0] OP_AND  = 8'b0010_0100;
  localparam logic [7:0] OP_OR   = 8'b0010_0101;
  localparam logic [7:0] OP_XOR  = 8'b0010_0110;
  localparam logic [7:0] OP_NOR  = 8'b0010_0111;
  localparam logic [7:0] OP_SLL  = 8'b0111_1100;
  localparam logic [7:0] OP_SRL  = 8'b0000_0010;
  localparam logic [7:0] OP_SRA  = 8'b0000_0011;
  localparam logic [7:0] OP_ADD  = 8'b0010_0000;
  localparam logic [7:0] OP_ADDU = 8'b0010_0001;
  localparam logic [7:0] OP_SUB  = 8'b0010_0010;
  localparam logic [7:0] OP_SUBU = 8'b0010_0011;
  localparam logic [7:0] OP_SLT  = 8'b0010_1010;
  localparam logic [7:0] OP_SLTU = 8'b0010_1011;

  // PC is reserved for future branch support.
  logic unused_pc;
  assign unused_pc = ^pc_i;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, sa;
  logic [15:0] imm16;

  assign op    = inst_i[31:26];
  assign rs    = inst_i[25:21];
  assign rt    = inst_i[20:16];
  assign rd    = inst_i[15:11];
  assign sa    = inst_i[10:6];
  assign funct = inst_i[5:0];
  assign imm16 = inst_i[15:0];

  logic        re1_d, re2_d, we_d;
  logic [7:0]  aluop_d;
  logic [2:0]  alusel_d;
  logic [4:0]  waddr_d;
  logic [31:0] imm_d, op1_d, op2_d;

  always_comb begin
    re1_d    = 1'b0;
    re2_d    = 1'b0;
    we_d     = 1'b0;
    aluop_d  = OP_NOP;
    alusel_d = SEL_NOP;
    waddr_d  = rd;
    imm_d    = 32'h0;
    if (op == 6'h00) begin
      // R-type: register-register forms read both ports and write rd.
      case (funct)
        6'h24, 6'h25, 6'h26, 6'h27: begin
          re1_d = 1'b1; re2_d = 1'b1; we_d = 1'b1; alusel_d = SEL_LOGIC;
          case (funct)
            6'h24:   aluop_d = OP_AND;
            6'h25:   aluop_d = OP_OR;
            6'h26:   aluop_d = OP_XOR;
            default: aluop_d = OP_NOR;
          endcase
        end
        6'h20, 6'h21, 6'h22, 6'h23, 6'h2A, 6'h2B: begin
          re1_d = 1'b1; re2_d = 1'b1; we_d = 1'b1; alusel_d = SEL_ARITH;
          case (funct)
            6'h20:   aluop_d = OP_ADD;
            6'h21:   aluop_d = OP_ADDU;
            6'h22:   aluop_d = OP_SUB;
            6'h23:   aluop_d = OP_SUBU;
            6'h2A:   aluop_d = OP_SLT;
            default: aluop_d = OP_SLTU;
          endcase
        end
        6'h04, 6'h06, 6'h07: begin
          re1_d = 1'b1; re2_d = 1'b1; we_d = 1'b1; alusel_d = SEL_SHIFT;
          case (funct)
            6'h04:   aluop_d = OP_SLL;
            6'h06:   aluop_d = OP_SRL;
            default: aluop_d = OP_SRA;
          endcase
        end
        6'h00, 6'h02, 6'h03: begin
          // Constant shifts are only legal with rs = 0; the shift amount
          // travels as operand 1 in place of a register read.
          if (rs == 5'd0) begin
            re2_d = 1'b1; we_d = 1'b1; alusel_d = SEL_SHIFT;
            imm_d = {27'h0, sa};
            case (funct)
              6'h00:   aluop_d = OP_SLL;
              6'h02:   aluop_d = OP_SRL;
              default: aluop_d = OP_SRA;
            endcase
          end
        end
        default: ;
      endcase
    end else begin
      case (op)
        6'h0C, 6'h0D, 6'h0E: begin
          re1_d = 1'b1; we_d = 1'b1; waddr_d = rt; alusel_d = SEL_LOGIC;
          imm_d = {16'h0, imm16};
          case (op)
            6'h0C:   aluop_d = OP_AND;
            6'h0D:   aluop_d = OP_OR;
            default: aluop_d = OP_XOR;
          endcase
        end
        6'h0F: begin
          // lui is executed as rs(=r0) OR {imm,16'h0}.
          re1_d = 1'b1; we_d = 1'b1; waddr_d = rt; alusel_d = SEL_LOGIC;
          aluop_d = OP_OR;
          imm_d = {imm16, 16'h0};
        end
        6'h08, 6'h09, 6'h0A, 6'h0B: begin
          re1_d = 1'b1; we_d = 1'b1; waddr_d = rt; alusel_d = SEL_ARITH;
          imm_d = {{16{imm16[15]}}, imm16};
          case (op)
            6'h08:   aluop_d = OP_ADD;
            6'h09:   aluop_d = OP_ADDU;
            6'h0A:   aluop_d = OP_SLT;
            default: aluop_d = OP_SLTU;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign re1_o    = rst ? 1'b0 : re1_d;
  assign re2_o    = rst ? 1'b0 : re2_d;
  assign raddr1_o = rst ? 5'd0 : rs;
  assign raddr2_o = rst ? 5'd0 : rt;

  assign op1_d = re1_o ? rdata1_i : imm_d;
  assign op2_d = re2_o ? rdata2_i : imm_d;

  logic        we_q;
  logic [7:0]  aluop_q;
  logic [2:0]  alusel_q;
  logic [4:0]  waddr_q;
  logic [31:0] op1_q, op2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q     <= 1'b0;
      aluop_q  <= OP_NOP;
      alusel_q <= SEL_NOP;
      waddr_q  <= 5'd0;
      op1_q    <= 32'h0;
      op2_q    <= 32'h0;
    end else begin
      we_q     <= we_d;
      aluop_q  <= aluop_d;
      alusel_q <= alusel_d;
      waddr_q  <= waddr_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
    end
  end

  assign aluop_o     = aluop_q;
  assign alusel_o    = alusel_q;
  assign rdata1_o    = op1_q;
  assign rdata2_o    = op2_q;
  assign waddr_reg_o = waddr_q;
  assign we_reg_o    = we_q;

endmodule
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_stage
// Purpose  : Scoreboard bench for id_stage. A driver applies directed and
//            random instructions, checks the combinational read controls and
//            queues the expected ID/EX contents; a monitor pops one entry per
//            rising edge and compares the registered outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i, inst_i, rdata1_i, rdata2_i;
  logic        re1_o, re2_o, we_reg_o;
  logic [4:0]  raddr1_o, raddr2_o, waddr_reg_o;
  logic [7:0]  aluop_o;
  logic [2:0]  alusel_o;
  logic [31:0] rdata1_o, rdata2_o;

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .inst_i(inst_i),
    .rdata1_i(rdata1_i), .rdata2_i(rdata2_i),
    .re1_o(re1_o), .re2_o(re2_o), .raddr1_o(raddr1_o), .raddr2_o(raddr2_o),
    .aluop_o(aluop_o), .alusel_o(alusel_o),
    .rdata1_o(rdata1_o), .rdata2_o(rdata2_o),
    .waddr_reg_o(waddr_reg_o), .we_reg_o(we_reg_o)
  );

  typedef struct packed {
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  waddr;
    logic        we;
  } exp_t;

  exp_t expq[$];
  int checks = 0;
  int failures = 0;

  // Reference decoder: instruction classified by mnemonic, each mnemonic
  // described by its operand sources, immediate form and ALU codes.
  typedef enum {K_BAD, K_RR, K_SHAMT, K_IZERO, K_ISIGN, K_LUI} kind_e;

  function automatic void ref_decode(input logic [31:0] ins,
                                     input logic [31:0] r1, input logic [31:0] r2,
                                     output logic re1, output logic re2,
                                     output exp_t e);
    kind_e       k = K_BAD;
    logic [7:0]  aop = 8'h00;
    logic [2:0]  asel = 3'b000;
    logic [31:0] imm = 0;
    int op = ins[31:26], fn = ins[5:0], rs = ins[25:21];
    if (op == 0) begin
      case (fn)
        'h24: begin k = K_RR; aop = 8'h24; asel = 3'b001; end
        'h25: begin k = K_RR; aop = 8'h25; asel = 3'b001; end
        'h26: begin k = K_RR; aop = 8'h26; asel = 3'b001; end
        'h27: begin k = K_RR; aop = 8'h27; asel = 3'b001; end
        'h20: begin k = K_RR; aop = 8'h20; asel = 3'b100; end
        'h21: begin k = K_RR; aop = 8'h21; asel = 3'b100; end
        'h22: begin k = K_RR; aop = 8'h22; asel = 3'b100; end
        'h23: begin k = K_RR; aop = 8'h23; asel = 3'b100; end
        'h2A: begin k = K_RR; aop = 8'h2A; asel = 3'b100; end
        'h2B: begin k = K_RR; aop = 8'h2B; asel = 3'b100; end
        'h04: begin k = K_RR; aop = 8'h7C; asel = 3'b010; end
        'h06: begin k = K_RR; aop = 8'h02; asel = 3'b010; end
        'h07: begin k = K_RR; aop = 8'h03; asel = 3'b010; end
        'h00: if (rs == 0) begin k = K_SHAMT; aop = 8'h7C; asel = 3'b010; end
        'h02: if (rs == 0) begin k = K_SHAMT; aop = 8'h02; asel = 3'b010; end
        'h03: if (rs == 0) begin k = K_SHAMT; aop = 8'h03; asel = 3'b010; end
        default: ;
      endcase
    end else begin
      case (op)
        'h0C: begin k = K_IZERO; aop = 8'h24; asel = 3'b001; end
        'h0D: begin k = K_IZERO; aop = 8'h25; asel = 3'b001; end
        'h0E: begin k = K_IZERO; aop = 8'h26; asel = 3'b001; end
        'h0F: begin k = K_LUI;   aop = 8'h25; asel = 3'b001; end
        'h08: begin k = K_ISIGN; aop = 8'h20; asel = 3'b100; end
        'h09: begin k = K_ISIGN; aop = 8'h21; asel = 3'b100; end
        'h0A: begin k = K_ISIGN; aop = 8'h2A; asel = 3'b100; end
        'h0B: begin k = K_ISIGN; aop = 8'h2B; asel = 3'b100; end
        default: ;
      endcase
    end
    case (k)
      K_SHAMT: imm = 32'(ins[10:6]);
      K_IZERO: imm = 32'(ins[15:0]);
      K_ISIGN: imm = 32'($signed(ins[15:0]));
      K_LUI:   imm = ins[15:0] * 32'h10000;
      default: imm = 0;
    endcase
    re1 = (k == K_RR) || (k == K_IZERO) || (k == K_ISIGN) || (k == K_LUI);
    re2 = (k == K_RR) || (k == K_SHAMT);
    e.aluop  = aop;
    e.alusel = asel;
    e.op1    = re1 ? r1 : imm;
    e.op2    = re2 ? r2 : imm;
    e.we     = (k != K_BAD);
    e.waddr  = (k == K_RR || k == K_SHAMT || k == K_BAD) ? ins[15:11] : ins[20:16];
  endfunction

  // Apply one cycle of stimulus (inputs settle before the next rising edge).
  task automatic drive(input logic r, input logic [31:0] ins,
                       input logic [31:0] d1, input logic [31:0] d2);
    logic re1, re2;
    logic [4:0] a1, a2;
    exp_t e;
    rst = r; inst_i = ins; rdata1_i = d1; rdata2_i = d2;
    pc_i = $urandom;
    ref_decode(ins, d1, d2, re1, re2, e);
    if (r) begin
      re1 = 0; re2 = 0; a1 = 0; a2 = 0; e = '0;
    end else begin
      a1 = ins[25:21]; a2 = ins[20:16];
    end
    #1;
    checks++;
    if ({re1_o, re2_o, raddr1_o, raddr2_o} !== {re1, re2, a1, a2}) begin
      failures++;
      $display("FAIL readctl inst=%08h rst=%0b got re=%0b%0b ra=%0d,%0d want re=%0b%0b ra=%0d,%0d",
               ins, r, re1_o, re2_o, raddr1_o, raddr2_o, re1, re2, a1, a2);
    end
    expq.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: the ID/EX register updates every edge, so one entry per edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        exp_t e;
        e = expq.pop_front();
        checks++;
        if ({aluop_o, alusel_o, rdata1_o, rdata2_o, waddr_reg_o, we_reg_o} !== e) begin
          failures++;
          $display("FAIL idex got aluop=%02h sel=%03b op1=%08h op2=%08h wa=%0d we=%0b want aluop=%02h sel=%03b op1=%08h op2=%08h wa=%0d we=%0b",
                   aluop_o, alusel_o, rdata1_o, rdata2_o, waddr_reg_o, we_reg_o,
                   e.aluop, e.alusel, e.op1, e.op2, e.waddr, e.we);
        end
      end
    end
  end

  logic [5:0] ops [12];
  logic [5:0] fns [20];

  initial begin
    ops = '{6'h00, 6'h00, 6'h00, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h23};
    fns = '{6'h24, 6'h25, 6'h26, 6'h27, 6'h20, 6'h21, 6'h22, 6'h23, 6'h2A, 6'h2B,
            6'h04, 6'h06, 6'h07, 6'h00, 6'h02, 6'h03, 6'h08, 6'h01, 6'h3F, 6'h05};
    rst = 1; inst_i = 0; rdata1_i = 0; rdata2_i = 0; pc_i = 0;

    // Reset held for 5 edges with an ori pending.
    repeat (5) drive(1, 32'h3421FFFF, 32'hDEADBEEF, 32'hCAFEF00D);
    drive(0, 32'h3421FFFF, 32'h0000_1111, 32'h0);
    // Directed decodes, back to back.
    drive(0, 32'h34418001, 32'h12340000, 32'h55555555);
    drive(0, 32'h2083FFFF, 32'h5, 32'h0);
    drive(0, 32'h3C05ABCD, 32'h0, 32'h77);
    drive(0, 32'h00073100, 32'h99, 32'h1);
    drive(0, 32'h012A4024, 32'hF0F0F0F0, 32'h0FF00FF0);
    drive(0, 32'hFC000000, 32'h11111111, 32'h22222222);
    drive(0, 32'h00000000, 32'h3, 32'h4);
    drive(0, 32'h00220080, 32'h3, 32'h4);       // sll with rs != 0: invalid
    drive(0, 32'h3021FFFF, 32'h0, 32'h0);       // andi zero-extends
    drive(1, 32'h012A4024, 32'h1, 32'h2);       // reset mid-stream
    drive(0, 32'h012A4024, 32'h1, 32'h2);

    // Random stream with occasional reset.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ins;
      int oi;
      ins = $urandom;
      oi = $urandom_range(0, 13);
      if (oi < 12) ins[31:26] = ops[oi];
      if (ins[31:26] == 0) begin
        ins[5:0] = fns[$urandom_range(0, 19)];
        if ($urandom_range(0, 1) == 1) ins[25:21] = 0;
      end
      drive($urandom_range(0, 29) == 0, ins, $urandom, $urandom);
    end

    drive(0, 32'h0, 32'h0, 32'h0);
    @(posedge clk);
    #2;
    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d want 0", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
